// File: rtl/regbank_dump_sequencer.sv
// ---------------------------------------------------------------------------
// regbank_dump_sequencer
//
// Debug-side controller that dumps the whole CPU register file over the UART.
// On a start request it stalls the pipeline and waits for the drain
// acknowledge. It then sends a sync header byte and walks every register
// address through read port A of the register bank, streaming each word to
// the UART transmitter most significant byte first. A one-cycle done pulse
// closes the dump and releases the pipeline.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset, drops any dump in flight
//   i_start      dump request, only looked at while idle
//   i_stall_ack  pipeline drained and halted (level)
//   i_rd_data    register bank read port A data (o_reg_A)
//   i_tx_ready   UART TX can accept a byte this cycle
//   o_stall_req  pipeline stall request, high from WAIT_ACK through DONE
//   o_rd_sel     debug owns the read-port-A address mux
//   o_rd_dir     read-port-A address
//   o_tx_data    byte offered to the UART TX
//   o_tx_valid   o_tx_data is valid
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse when the dump has completed
// ---------------------------------------------------------------------------
module regbank_dump_sequencer #(
    parameter int         SIZE          = 32,
    parameter int         NUM_REGISTERS = 32,
    parameter int         SIZE_REG_DIR  = $clog2(NUM_REGISTERS),
    parameter logic [7:0] HEADER        = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_stall_ack,
    input  logic [SIZE-1:0]         i_rd_data,
    input  logic                    i_tx_ready,
    output logic                    o_stall_req,
    output logic                    o_rd_sel,
    output logic [SIZE_REG_DIR-1:0] o_rd_dir,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int NUM_BYTES = SIZE / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0]        LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [SIZE_REG_DIR-1:0] LAST_REG  = SIZE_REG_DIR'(NUM_REGISTERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_HDR,
        ST_ADDR,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                  r_state;
    logic [SIZE_REG_DIR-1:0] r_index;
    logic [CNT_W-1:0]        r_count;
    logic [SIZE-1:0]         r_latch;
    logic                    r_stall_req;
    logic                    r_rd_sel;
    logic [7:0]              r_tx_data;
    logic                    r_tx_valid;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_tx_handshake;
    logic                    w_last_byte;
    logic                    w_last_reg;
    logic [CNT_W:0]          w_count_inc;
    logic [SIZE-1:0]         w_shifted;
    logic [7:0]              w_next_byte;

    // A byte leaves only when the offered byte meets a ready UART at the edge.
    // The next byte of the latched word is picked by shifting the word left by
    // the byte position that follows the current one; the extra count bit
    // keeps the position from wrapping before it is scaled to a bit offset.
    assign w_tx_handshake = r_tx_valid & i_tx_ready;
    assign w_last_byte    = (r_count == LAST_BYTE);
    assign w_last_reg     = (r_index == LAST_REG);
    assign w_count_inc    = {1'b0, r_count} + 1'b1;
    assign w_shifted      = r_latch << {w_count_inc, 3'b000};
    assign w_next_byte    = w_shifted[SIZE-1 -: 8];

    // Dump sequencer. All outputs are registers that are loaded on the same
    // edge that enters the state they belong to, so every output is already
    // correct in the first cycle of its state. The address register doubles
    // as o_rd_dir, which keeps the address steady through ADDR, LATCH and
    // SEND. The bank refreshes port A on the falling edge inside ADDR, so the
    // word is safely captured on the edge that leaves LATCH, and the first
    // byte is loaded straight from the bank data on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_count     <= '0;
            r_latch     <= '0;
            r_stall_req <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state     <= ST_WAIT_ACK;
                        r_stall_req <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                ST_WAIT_ACK: begin
                    if (i_stall_ack) begin
                        r_state    <= ST_HDR;
                        r_index    <= '0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= HEADER;
                    end
                end

                ST_HDR: begin
                    if (w_tx_handshake) begin
                        r_state    <= ST_ADDR;
                        r_tx_valid <= 1'b0;
                        r_rd_sel   <= 1'b1;
                    end
                end

                ST_ADDR: begin
                    r_state <= ST_LATCH;
                end

                ST_LATCH: begin
                    r_state    <= ST_SEND;
                    r_latch    <= i_rd_data;
                    r_count    <= '0;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= i_rd_data[SIZE-1 -: 8];
                end

                ST_SEND: begin
                    if (w_tx_handshake) begin
                        if (!w_last_byte) begin
                            r_count   <= r_count + 1'b1;
                            r_tx_data <= w_next_byte;
                        end else if (w_last_reg) begin
                            r_state    <= ST_DONE;
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state    <= ST_ADDR;
                            r_tx_valid <= 1'b0;
                            r_index    <= r_index + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_stall_req <= 1'b0;
                    r_rd_sel    <= 1'b0;
                    r_busy      <= 1'b0;
                    r_index     <= '0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from their registers.
    assign o_stall_req = r_stall_req;
    assign o_rd_sel    = r_rd_sel;
    assign o_rd_dir    = r_index;
    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = r_tx_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: doc/regbank_dump_sequencer.md
Name: regbank_dump_sequencer

Overview:
- Debug-side controller for the CPU register file.
- On request, it stalls the pipeline and waits for the pipeline's drain acknowledge.
- It then walks every register address through the register bank's read port A and streams each word, MSB byte first, to the UART transmitter over a valid/ready byte interface.
- Sits between the debug unit (start/done), the pipeline control (stall handshake), the register bank (read port A address mux) and the UART TX.

Parameters:
- SIZE, 32, register width in bits; must be a multiple of 8.
- NUM_REGISTERS, 32, number of registers dumped, addresses 0..NUM_REGISTERS-1.
- SIZE_REG_DIR, $clog2(NUM_REGISTERS), register address width.
- HEADER, 8'hA5, sync byte sent before the first register.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- i_start  input  1  dump request; sampled only in IDLE.
- i_stall_ack  input  1  pipeline drained and halted; level signal.
- i_rd_data  input  SIZE  register bank o_reg_A.
- i_tx_ready  input  1  UART TX can accept a byte.
- o_stall_req  output  1  pipeline stall request.
- o_rd_sel  output  1  1 = debug owns the read-port-A address mux.
- o_rd_dir  output  SIZE_REG_DIR  read address for port A.
- o_tx_data  output  8  byte to transmit.
- o_tx_valid  output  1  o_tx_data valid.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, any state, mid-dump included):
  - state=IDLE.
  - all outputs 0.
  - reg index=0, byte count=0, word latch=0.
  - Any in-flight transfer is dropped, with no completion pulse.
- IDLE:
  - i_start=1 -> WAIT_ACK, and o_stall_req=1 from the next cycle.
  - i_start while busy is ignored and not queued.
- WAIT_ACK:
  - o_stall_req=1.
  - i_stall_ack=1 -> HDR. Wait is unbounded.
- HDR:
  - o_tx_valid=1, o_tx_data=HEADER.
  - On i_tx_ready=1 (handshake = valid&ready at posedge) -> ADDR.
  - index=0.
- ADDR:
  - o_rd_sel=1, o_rd_dir=index.
  - One full cycle, because the bank updates port A on the negative edge.
  - -> LATCH.
- LATCH:
  - o_rd_dir held.
  - i_rd_data captured into the word latch at this posedge.
  - byte count=0.
  - -> SEND.
- SEND:
  - o_tx_valid=1.
  - o_tx_data = latch[SIZE-1-8*count -: 8], i.e. the MSB byte first.
  - o_tx_data and o_tx_valid stay stable until the handshake.
  - On handshake:
    - if count < SIZE/8-1: count++ and stay in SEND;
    - else if index = NUM_REGISTERS-1: -> DONE;
    - else index++ and -> ADDR.
- DONE:
  - o_done=1 for exactly one cycle.
  - o_stall_req, o_rd_sel and o_busy drop in the next cycle.
  - -> IDLE.
- o_rd_sel:
  - 1 in ADDR, LATCH and SEND.
  - Because the pipeline is stalled, no write-back occurs during the dump and register contents are static.
- Stall handling: o_stall_req is held 1 continuously from WAIT_ACK through DONE. If i_stall_ack falls during a dump it is ignored, so the protocol must keep it high.
- Counts:
  - index wraps never: a terminal compare ends the dump.
  - Byte count width is $clog2(SIZE/8), minimum 1 bit.
- Throughput: with i_tx_ready tied 1, each register costs 2 + SIZE/8 cycles. A full default dump is 1 + 32×6 = 193 cycles from HDR entry to DONE.
- Back-to-back: i_start asserted in the cycle after DONE (state IDLE) starts a new dump.

Test Plan:
- Basic dump:
  - Stimulus: preload regs r0=0, r1=32'h11223344, r31=32'hDEADBEEF; i_start pulse; i_stall_ack=1 two cycles after o_stall_req; tx_ready=1.
  - Required response:
    - byte stream A5, 00 00 00 00, 11 22 33 44, …, DE AD BE EF (129 bytes);
    - o_done pulses once, 193 cycles after HDR entry.
- Backpressure:
  - Stimulus: i_tx_ready toggled pseudo-randomly (about 30% high).
  - Required response:
    - identical byte sequence;
    - o_tx_data stable while o_tx_valid=1 and ready=0;
    - no byte duplicated or lost.
- Stall handshake:
  - Stimulus: hold i_stall_ack=0 for 50 cycles after start.
  - Required response: no o_tx_valid and no o_rd_sel until the cycle after ack rises; o_busy=1 throughout.
- Reset mid-dump:
  - Stimulus: assert rst asynchronously (between edges) during SEND of r7 byte 2.
  - Required response:
    - all outputs 0 immediately, with no o_done;
    - a subsequent i_start restarts from HEADER and r0.
- Ignored start:
  - Stimulus: pulse i_start repeatedly during a dump.
  - Required response: exactly one dump and one o_done; a start in the first IDLE cycle after DONE begins a second dump.
- Address timing:
  - Check: o_rd_dir=k held through ADDR and LATCH.
  - Required response: the captured word equals the bank contents of rk (checked with the bank's negedge read model), for k = 0, 1, 30, 31.
